// File: rtl/ws2812_stream_tx.sv
// WS2812 serial transmitter: streams N_LEDS pixel words, MSB first, as
// T_BIT-cycle pulses (T1H high for a 1, T0H high for a 0). The frame ends
// with a T_RESET-cycle low latch period. A one-word holding register
// decouples the pixel source from the bit shifter.
module ws2812_stream_tx #(
   parameter int N_LEDS       = 60,
   parameter int BITS_PER_LED = 24,
   parameter int T0H          = 20,
   parameter int T1H          = 40,
   parameter int T_BIT        = 63,
   parameter int T_RESET      = 2500
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [BITS_PER_LED-1:0] px_data,
   input  logic                    px_valid,
   output logic                    px_ready,
   output logic                    ws2812_dout,
   output logic                    busy,
   output logic                    frame_done,
   output logic                    underrun
);

   localparam int PIX_W   = $clog2(N_LEDS + 1);
   localparam int BIT_W   = $clog2(BITS_PER_LED);
   localparam int CYC_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
   localparam int CYC_W   = $clog2(CYC_MAX);
   localparam int MSB     = BITS_PER_LED - 1;

   // Reject timing/format combinations the line encoding cannot represent.
   generate
      if (!(T0H < T1H && T1H < T_BIT) || !(BITS_PER_LED == 24 || BITS_PER_LED == 32) ||
          N_LEDS < 1 || T_RESET < 1) begin : g_bad_params
         $error("ws2812_stream_tx: illegal parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, WAIT_FIRST, SEND, LATCH} state_t;

   state_t                  state;
   logic [BITS_PER_LED-1:0] hold_q;
   logic [BITS_PER_LED-1:0] shift_q;
   logic                    hold_full;
   logic                    primed;     // first bit of the frame is on the line
   logic [PIX_W-1:0]        pix_cnt;    // words accepted this frame
   logic [BIT_W-1:0]        bit_cnt;
   logic [CYC_W-1:0]        cyc_cnt;
   logic                    xfer;

   // Line level for position c of a bit with value b.
   function automatic logic high_at(input logic b, input int c);
      return (c < (b ? T1H : T0H));
   endfunction

   assign px_ready = (state == WAIT_FIRST || state == SEND) && !hold_full &&
                     (pix_cnt < PIX_W'(N_LEDS));
   assign xfer     = px_valid && px_ready;
   assign busy     = (state != IDLE);

   // Frame sequencer, holding register, shifter and registered line output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         hold_q      <= '0;
         shift_q     <= '0;
         hold_full   <= 1'b0;
         primed      <= 1'b0;
         pix_cnt     <= '0;
         bit_cnt     <= '0;
         cyc_cnt     <= '0;
         ws2812_dout <= 1'b0;
         frame_done  <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // Accepted words land in the holding register; the pixel-end
         // bypass below may send one straight to the shifter instead.
         if (xfer) begin
            hold_q    <= px_data;
            hold_full <= 1'b1;
            pix_cnt   <= pix_cnt + PIX_W'(1);
         end
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= WAIT_FIRST;
                  underrun  <= 1'b0;
                  pix_cnt   <= '0;
                  hold_full <= 1'b0;
               end
            end
            WAIT_FIRST: begin
               if (hold_full) begin
                  shift_q   <= hold_q;
                  hold_full <= 1'b0;
                  bit_cnt   <= '0;
                  cyc_cnt   <= '0;
                  primed    <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (!primed) begin
                  // One load cycle after entering SEND, then bit 0 begins.
                  primed      <= 1'b1;
                  ws2812_dout <= high_at(shift_q[MSB], 0);
               end else if (cyc_cnt != CYC_W'(T_BIT - 1)) begin
                  cyc_cnt     <= cyc_cnt + CYC_W'(1);
                  ws2812_dout <= high_at(shift_q[MSB], int'(cyc_cnt) + 1);
               end else begin
                  cyc_cnt <= '0;
                  if (bit_cnt != BIT_W'(BITS_PER_LED - 1)) begin
                     bit_cnt     <= bit_cnt + BIT_W'(1);
                     shift_q     <= shift_q << 1;
                     ws2812_dout <= high_at(shift_q[MSB-1], 0);
                  end else begin
                     bit_cnt <= '0;
                     if (hold_full) begin
                        shift_q     <= hold_q;
                        hold_full   <= 1'b0;
                        ws2812_dout <= high_at(hold_q[MSB], 0);
                     end else if (xfer) begin
                        // Word arriving on the pixel boundary goes straight out.
                        shift_q     <= px_data;
                        hold_full   <= 1'b0;
                        ws2812_dout <= high_at(px_data[MSB], 0);
                     end else begin
                        if (pix_cnt != PIX_W'(N_LEDS)) underrun <= 1'b1;
                        state       <= LATCH;
                        ws2812_dout <= 1'b0;
                     end
                  end
               end
            end
            LATCH: begin
               if (cyc_cnt == CYC_W'(T_RESET - 1)) begin
                  cyc_cnt    <= '0;
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end else begin
                  cyc_cnt <= cyc_cnt + CYC_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_stream_tx.sv
// Bench for ws2812_stream_tx: three instances (3x GRB, 1x GRB, 1x GRBW)
// driven from a frame table plus randomized frames; the expected line is
// computed from the pixel words with plain timing arithmetic.
module tb_ws2812_stream_tx;

   localparam int T0H   = 20;
   localparam int T1H   = 40;
   localparam int T_BIT = 63;
   localparam int LIMIT = 8000;
   localparam int N_OF   [3] = '{3, 1, 1};
   localparam int BPL_OF [3] = '{24, 24, 32};
   localparam int TRES_OF[3] = '{40, 10, 10};

   logic        clk;
   logic        rst_n;
   logic [2:0]  start_v, valid_v;
   logic [31:0] data_s;
   logic [2:0]  ready_v, dout_v, busy_v, done_v, urun_v;

   int vectors, miscompares;
   logic [31:0] pixq[$];
   logic        chain_pending;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ws2812_stream_tx #(.N_LEDS(3), .BITS_PER_LED(24), .T_RESET(40)) u_d3 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .px_data(data_s[23:0]),
      .px_valid(valid_v[0]), .px_ready(ready_v[0]), .ws2812_dout(dout_v[0]),
      .busy(busy_v[0]), .frame_done(done_v[0]), .underrun(urun_v[0]));

   ws2812_stream_tx #(.N_LEDS(1), .BITS_PER_LED(24), .T_RESET(10)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .px_data(data_s[23:0]),
      .px_valid(valid_v[1]), .px_ready(ready_v[1]), .ws2812_dout(dout_v[1]),
      .busy(busy_v[1]), .frame_done(done_v[1]), .underrun(urun_v[1]));

   ws2812_stream_tx #(.N_LEDS(1), .BITS_PER_LED(32), .T_RESET(10)) u_dw (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .px_data(data_s),
      .px_valid(valid_v[2]), .px_ready(ready_v[2]), .ws2812_dout(dout_v[2]),
      .busy(busy_v[2]), .frame_done(done_v[2]), .underrun(urun_v[2]));

   typedef struct {
      int          sel;
      int          n_given;
      int          gap_max;
      logic [31:0] px0, px1, px2;
      logic        exp_urun;
      logic        chain;
   } frame_vec_t;

   frame_vec_t tbl[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Runs one frame on instance s using the first n_given words of pixq and
   // checks {dout,busy,frame_done,underrun} every cycle against the model.
   task automatic run_frame(input int s, input int n_given, input int gap_max,
                            input logic exp_urun, input logic chain_next);
      int   bpl, tres, sent, nf, gaps, btot, rel, bi, c, b;
      logic xfer_next, done_seen, e_dout, e_busy, e_done, e_ur;
      logic [31:0] w;
      bpl = BPL_OF[s]; tres = TRES_OF[s];
      sent = 0; nf = -1; xfer_next = 1'b0; done_seen = 1'b0; rel = -1;
      btot = n_given * bpl * T_BIT;
      gaps = $urandom_range(gap_max, 0);
      if (!chain_pending) begin
         @(negedge clk);
         start_v[s] = 1'b1;
      end
      chain_pending = 1'b0;
      for (int cyc = 0; cyc < LIMIT && !done_seen; cyc++) begin
         @(negedge clk);
         start_v = '0;
         valid_v = '0;
         if (xfer_next) begin
            sent++;
            if (nf < 0) nf = cyc;
            gaps = $urandom_range(gap_max, 0);
         end
         e_dout = 1'b0; e_busy = 1'b1; e_done = 1'b0; e_ur = 1'b0;
         if (nf >= 0) begin
            rel = cyc - (nf + 2);
            if (rel >= 0 && rel < btot) begin
               bi = rel / T_BIT;
               c  = rel % T_BIT;
               w  = pixq[bi / bpl];
               b  = bpl - 1 - (bi % bpl);
               e_dout = (c < (w[b] ? T1H : T0H));
            end else if (rel >= btot) begin
               e_ur = exp_urun;
               if (rel == btot + tres) begin
                  e_busy = 1'b0;
                  e_done = 1'b1;
                  done_seen = 1'b1;
               end
            end
         end
         check($sformatf("frame s%0d cyc%0d rel%0d {dout,busy,done,urun}", s, cyc, rel),
               {28'd0, dout_v[s], busy_v[s], done_v[s], urun_v[s]},
               {28'd0, e_dout, e_busy, e_done, e_ur});
         if (sent >= N_OF[s]) check("ready_after_n", {31'd0, ready_v[s]}, 32'd0);
         if (done_seen) begin
            if (chain_next) begin
               start_v[s] = 1'b1;
               chain_pending = 1'b1;
            end
         end else begin
            if (gaps > 0) gaps--;
            else if (sent < n_given) begin
               valid_v[s] = 1'b1;
               data_s     = pixq[sent];
            end
            xfer_next = valid_v[s] && ready_v[s];
            // Stray start while the frame runs must be ignored.
            if ($urandom_range(99, 0) == 0) start_v[s] = 1'b1;
         end
      end
      if (!done_seen) check("frame_timeout", 32'd1, 32'd0);
      check("xfer_count", sent, n_given);
   endtask

   initial begin
      vectors = 0; miscompares = 0; chain_pending = 1'b0;
      start_v = '0; valid_v = '0; data_s = '0;
      tbl[0] = '{1, 1, 0,   32'h800001, 32'h0,      32'h0,      1'b0, 1'b0};
      tbl[1] = '{0, 3, 0,   32'hFFFFFF, 32'h000000, 32'hA5C33C, 1'b0, 1'b1};
      tbl[2] = '{0, 1, 0,   32'h123456, 32'h0,      32'h0,      1'b1, 1'b0};
      tbl[3] = '{0, 3, 100, 32'h0F0F0F, 32'hF0F0F0, 32'h555555, 1'b0, 1'b0};
      tbl[4] = '{2, 1, 0,   32'h000000FF, 32'h0,    32'h0,      1'b0, 1'b0};
      tbl[5] = '{2, 1, 30,  32'h80000001, 32'h0,    32'h0,      1'b0, 1'b0};

      rst_n = 1'b0;
      #1;
      check("reset_state", {17'd0, dout_v, busy_v, done_v, urun_v, ready_v}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         pixq = {};
         pixq.push_back(tbl[i].px0);
         pixq.push_back(tbl[i].px1);
         pixq.push_back(tbl[i].px2);
         run_frame(tbl[i].sel, tbl[i].n_given, tbl[i].gap_max, tbl[i].exp_urun, tbl[i].chain);
      end

      // Randomized frames on the three-pixel instance, some with withheld data.
      for (int r = 0; r < 6; r++) begin
         int ng;
         pixq = {};
         for (int k = 0; k < 3; k++) pixq.push_back({8'd0, 24'($urandom)});
         ng = $urandom_range(3, 1);
         run_frame(0, ng, 150, (ng < 3), (r < 5) ? 1'($urandom_range(1, 0)) : 1'b0);
      end

      // Reset asserted in the middle of a high pulse.
      begin
         int hi_cnt;
         hi_cnt = 0;
         @(negedge clk);
         start_v[0] = 1'b1;
         for (int cyc = 0; cyc < 200 && hi_cnt < 5; cyc++) begin
            @(negedge clk);
            start_v[0] = 1'b0;
            valid_v[0] = 1'b1;
            data_s     = 32'h00FFFFFF;
            if (dout_v[0]) hi_cnt++;
         end
         check("midbit_reached_high", hi_cnt, 5);
         #1 rst_n = 1'b0;
         #1;
         check("midbit_reset_outputs", {29'd0, dout_v[0], busy_v[0], ready_v[0]}, 32'd0);
         @(negedge clk);
         rst_n = 1'b1;
         for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            check("post_reset_idle", {30'd0, dout_v[0], busy_v[0]}, 32'd0);
         end
         valid_v = '0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
